cv32e40p_xif_mac_copro: RTL and testbench

CV32E40P_XIF_MAC_COPRO -- requirements
Module: cv32e40p_xif_mac_copro

---
 rtl/cv32e40p_core_v_xif_pkg.sv | 46 ++++
 rtl/cv32e40p_xif_mac_pkg.sv | 35 +++
 rtl/cv32e40p_xif_mac_copro.sv | 188 ++++++++++++++++++
 tb/tb_cv32e40p_xif_mac_copro.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_core_v_xif_pkg.sv
// cv32e40p_core_v_xif_pkg
// Types shared by the core and every coprocessor on the CORE-V eXtension
// interface (issue, commit and result channels only). The compressed and
// memory channels are tied off by the integrating wrapper, so they are not
// modelled here.
package cv32e40p_core_v_xif_pkg;

  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_NUM_RS    = 2;
  localparam int unsigned X_RFR_WIDTH = 32;
  localparam int unsigned X_RFW_WIDTH = 32;

  typedef struct packed {
    logic [31:0]                              instr;
    logic [1:0]                               mode;
    logic [X_ID_WIDTH-1:0]                    id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]     rs;
    logic [X_NUM_RS-1:0]                      rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic float;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   float;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

endpackage

// File: rtl/cv32e40p_xif_mac_pkg.sv
// cv32e40p_xif_mac_pkg
// Opcode, operation and FSM encodings for the multiply/accumulate
// coprocessor, plus the decoder that tells whether an instruction is ours.
// Optional feature macro: XIF_MAC_ACC_EN (accumulator ops MAC / ACCRD).
package cv32e40p_xif_mac_pkg;

  localparam logic [6:0] MAC_OPCODE = 7'b0001011;

  typedef enum logic [2:0] {
    FUNCT3_MUL   = 3'b000,
    FUNCT3_MAC   = 3'b001,
    FUNCT3_ACCRD = 3'b010
  } mac_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_COMMIT = 2'd1,
    ST_EXEC        = 2'd2,
    ST_RESULT      = 2'd3
  } mac_state_e;

  // An instruction is ours when the custom-0 opcode, a zero funct7 and a
  // funct3 supported by this build all line up.
  function automatic logic is_own_instr(input logic [31:0] instr);
    logic f3_ok;
`ifdef XIF_MAC_ACC_EN
    f3_ok = (instr[14:12] == FUNCT3_MUL) || (instr[14:12] == FUNCT3_MAC) ||
            (instr[14:12] == FUNCT3_ACCRD);
`else
    f3_ok = (instr[14:12] == FUNCT3_MUL);
`endif
    return (instr[6:0] == MAC_OPCODE) && (instr[31:25] == 7'b0) && f3_ok;
  endfunction

endpackage

// File: rtl/cv32e40p_xif_mac_copro.sv
// cv32e40p_xif_mac_copro
// Single-outstanding multiply / multiply-accumulate coprocessor on the
// CORE-V XIF issue, commit and result channels.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and
// ready are both 1. Ready never depends on anything but state and the
// offered request; valid, once raised on the result channel, holds with
// stable payload until ready is seen.
//
// Ports
//   clk_i, rst_i                     clock, async active-high reset
//   x_issue_valid_i/ready_o/req_i/resp_o   issue channel (resp is
//                                    combinational, valid in the ready cycle)
//   x_commit_valid_i, x_commit_i     commit strobe with id and kill
//   x_result_valid_o/ready_i/o       result channel (registered)
//   dbg_state_o                      current FSM state for observation
//
// Parameter EXEC_LATENCY (1..15): cycles spent in EXEC after the commit.
// Macro XIF_MAC_ACC_EN enables the accumulator and the MAC/ACCRD ops;
// without it only MUL is accepted and no accumulator register exists.
module cv32e40p_xif_mac_copro
  import cv32e40p_core_v_xif_pkg::*;
  import cv32e40p_xif_mac_pkg::*;
#(
  parameter int unsigned EXEC_LATENCY = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          x_issue_valid_i,
  output logic          x_issue_ready_o,
  input  x_issue_req_t  x_issue_req_i,
  output x_issue_resp_t x_issue_resp_o,
  input  logic          x_commit_valid_i,
  input  x_commit_t     x_commit_i,
  output logic          x_result_valid_o,
  input  logic          x_result_ready_i,
  output x_result_t     x_result_o,
  output mac_state_e    dbg_state_o
);

  // EXEC is entered with EXEC_LATENCY-1 and leaves when the counter hits 0,
  // so EXEC lasts exactly EXEC_LATENCY cycles.
  localparam logic [3:0] CNT_LOAD = 4'(EXEC_LATENCY - 1);

  mac_state_e            state_q;
  logic [3:0]            cnt_q;
  logic [X_ID_WIDTH-1:0] id_q;
  logic [4:0]            rd_q;
  logic [31:0]           rs1_q;
  logic [31:0]           rs2_q;
  logic                  result_valid_q;
  x_result_t             result_q;
`ifdef XIF_MAC_ACC_EN
  mac_funct3_e           funct3_q;
  logic [31:0]           acc_q;
`endif

  logic        own;
  logic        issue_ready;
  logic        issue_hs;
  logic        commit_on_issue;
  logic        commit_in_wait;
  logic [31:0] prod;
  logic [31:0] exec_data;
  logic        unused_bits;

  assign own = is_own_instr(x_issue_req_i.instr);

  // Foreign instructions are always answered at once (with accept=0) so the
  // core is never stalled by us; our own ones wait for both operands.
  assign issue_ready = !rst_i && (state_q == ST_IDLE) &&
                       (!own || (x_issue_req_i.rs_valid == 2'b11));
  assign issue_hs    = x_issue_valid_i && issue_ready;

  // The id is not latched yet in the issue cycle, so a same-cycle commit is
  // matched against the id on the issue request.
  assign commit_on_issue = x_commit_valid_i && (x_commit_i.id == x_issue_req_i.id);
  assign commit_in_wait  = x_commit_valid_i && (x_commit_i.id == id_q);

  // Unsigned product truncated to 32 bits (modulo 2^32).
  assign prod = rs1_q * rs2_q;

  always_comb begin
    exec_data = prod;
`ifdef XIF_MAC_ACC_EN
    case (funct3_q)
      FUNCT3_MAC:   exec_data = acc_q + prod;
      FUNCT3_ACCRD: exec_data = acc_q;
      default:      exec_data = prod;
    endcase
`endif
  end

  always_comb begin
    x_issue_resp_o           = '0;
    x_issue_resp_o.accept    = issue_ready && own;
    x_issue_resp_o.writeback = issue_ready && own;
  end

  assign x_issue_ready_o  = issue_ready;
  assign x_result_valid_o = result_valid_q;
  assign x_result_o       = result_q;
  assign dbg_state_o      = state_q;

  // Source-register addresses and privilege mode play no part here.
  assign unused_bits = ^{x_issue_req_i.mode, x_issue_req_i.instr[24:15]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      id_q           <= '0;
      rd_q           <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
`ifdef XIF_MAC_ACC_EN
      funct3_q       <= FUNCT3_MUL;
      acc_q          <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_hs && own) begin
            id_q  <= x_issue_req_i.id;
            rd_q  <= x_issue_req_i.instr[11:7];
            rs1_q <= x_issue_req_i.rs[0];
            rs2_q <= x_issue_req_i.rs[1];
`ifdef XIF_MAC_ACC_EN
            funct3_q <= mac_funct3_e'(x_issue_req_i.instr[14:12]);
`endif
            if (commit_on_issue) begin
              if (x_commit_i.commit_kill) begin
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_EXEC;
                cnt_q   <= CNT_LOAD;
              end
            end else begin
              state_q <= ST_WAIT_COMMIT;
            end
          end
        end
        ST_WAIT_COMMIT: begin
          if (commit_in_wait) begin
            if (x_commit_i.commit_kill) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_EXEC;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_q == 4'd0) begin
            state_q          <= ST_RESULT;
            result_valid_q   <= 1'b1;
            result_q         <= '0;
            result_q.id      <= id_q;
            result_q.data    <= exec_data;
            result_q.rd      <= rd_q;
            result_q.we      <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESULT: begin
          if (x_result_ready_i) begin
            state_q        <= ST_IDLE;
            result_valid_q <= 1'b0;
            result_q       <= '0;
`ifdef XIF_MAC_ACC_EN
            // The accumulator only moves once the core has taken the result.
            if (funct3_q == FUNCT3_MAC) begin
              acc_q <= exec_data;
            end else if (funct3_q == FUNCT3_ACCRD) begin
              acc_q <= '0;
            end
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40p_xif_mac_copro.sv
// tb_cv32e40p_xif_mac_copro
// Directed scenarios followed by randomized transactions, each checked
// against a behavioural model of the coprocessor (accumulator value,
// accept rule and result latency computed from plain arithmetic).
module tb_cv32e40p_xif_mac_copro;
  import cv32e40p_core_v_xif_pkg::*;
  import cv32e40p_xif_mac_pkg::*;

  localparam int unsigned LAT = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          x_issue_valid_i;
  logic          x_issue_ready_o;
  x_issue_req_t  x_issue_req_i;
  x_issue_resp_t x_issue_resp_o;
  logic          x_commit_valid_i;
  x_commit_t     x_commit_i;
  logic          x_result_valid_o;
  logic          x_result_ready_i;
  x_result_t     x_result_o;
  mac_state_e    dbg_state_o;

  always #5 clk = ~clk;

  int unsigned cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  cv32e40p_xif_mac_copro #(.EXEC_LATENCY(LAT)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .x_issue_valid_i  (x_issue_valid_i),
    .x_issue_ready_o  (x_issue_ready_o),
    .x_issue_req_i    (x_issue_req_i),
    .x_issue_resp_o   (x_issue_resp_o),
    .x_commit_valid_i (x_commit_valid_i),
    .x_commit_i       (x_commit_i),
    .x_result_valid_o (x_result_valid_o),
    .x_result_ready_i (x_result_ready_i),
    .x_result_o       (x_result_o),
    .dbg_state_o      (dbg_state_o)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cycle_cnt);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_acc = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_accepts(input logic [2:0] f3);
`ifdef XIF_MAC_ACC_EN
    return f3 <= 3'd2;
`else
    return f3 == 3'd0;
`endif
  endfunction

  // Result of a committed op; advances the accumulator as the op dictates.
  function automatic logic [31:0] model_exec(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint unsigned p;
    logic [31:0] r;
    p = (longint'(a) * longint'(b)) % 64'h1_0000_0000;
    r = 32'(p);
    if (f3 == 3'd1) begin
      model_acc = model_acc + r;
      return model_acc;
    end else if (f3 == 3'd2) begin
      r = model_acc;
      model_acc = '0;
      return r;
    end
    return r;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [4:0] rd);
    return {7'b0, 5'd2, 5'd1, f3, rd, op};
  endfunction

  // ---------------- driver tasks (start and end at a negedge) ----------------
  task automatic idle_inputs();
    x_issue_valid_i  = 1'b0;
    x_issue_req_i    = '0;
    x_commit_valid_i = 1'b0;
    x_commit_i       = '0;
  endtask

  task automatic issue_op(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] id, input logic [1:0] rsv, input bit with_commit,
                          input bit kill, output logic accepted, output int unsigned hs_cyc,
                          output bit ok);
    x_issue_valid_i          = 1'b1;
    x_issue_req_i            = '0;
    x_issue_req_i.instr      = instr;
    x_issue_req_i.rs[0]      = a;
    x_issue_req_i.rs[1]      = b;
    x_issue_req_i.id         = id;
    x_issue_req_i.rs_valid   = rsv;
    if (with_commit) begin
      x_commit_valid_i       = 1'b1;
      x_commit_i.id          = id;
      x_commit_i.commit_kill = kill;
    end
    ok = 1'b0; accepted = 1'b0; hs_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (x_issue_ready_o) begin
        ok = 1'b1;
        accepted = x_issue_resp_o.accept;
        hs_cyc = cycle_cnt;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic commit_drive(input logic [3:0] id, input bit kill, output int unsigned cyc);
    x_commit_valid_i       = 1'b1;
    x_commit_i.id          = id;
    x_commit_i.commit_kill = kill;
    cyc = cycle_cnt;
    @(negedge clk);
    x_commit_valid_i = 1'b0;
    x_commit_i       = '0;
  endtask

  task automatic watch_no_result(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < int'(LAT) + 4; i++) begin
      if (x_result_valid_o) seen = 1'b1;
      @(negedge clk);
    end
    check({tag, " no_result"}, 64'(seen), 64'(0));
    check({tag, " idle"}, 64'(dbg_state_o), 64'(ST_IDLE));
  endtask

  task automatic wait_result(input int unsigned from_cyc, input string tag, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < int'(LAT) + 10; i++) begin
      if (x_result_valid_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, " result_seen"}, 64'(seen), 64'(1));
    if (seen) check({tag, " latency"}, 64'(cycle_cnt - from_cyc), 64'(LAT + 1));
  endtask

  task automatic collect_result(input int unsigned rdelay, input logic [3:0] id,
                                input logic [4:0] rd, input string tag);
    x_result_t   snap;
    logic [31:0] exp;
    snap = x_result_o;
    for (int i = 0; i < int'(rdelay); i++) begin
      x_result_ready_i = 1'b0;
      check({tag, " bp_issue_ready"}, 64'(x_issue_ready_o), 64'(0));
      @(negedge clk);
      check({tag, " bp_valid"}, 64'(x_result_valid_o), 64'(1));
      check({tag, " bp_stable"}, 64'(x_result_o), 64'(snap));
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
    check({tag, " data"}, 64'(x_result_o.data), 64'(exp));
    check({tag, " id"}, 64'(x_result_o.id), 64'(id));
    check({tag, " rd"}, 64'(x_result_o.rd), 64'(rd));
    check({tag, " we_float_exc"},
          64'({x_result_o.we, x_result_o.float, x_result_o.exc, x_result_o.exccode}),
          64'({1'b1, 1'b0, 1'b0, 6'd0}));
    x_result_ready_i = 1'b1;
    @(negedge clk);
    x_result_ready_i = 1'b0;
    check({tag, " post_valid"}, 64'(x_result_valid_o), 64'(0));
    check({tag, " post_idle"}, 64'(dbg_state_o), 64'(ST_IDLE));
    #1;
    check({tag, " post_ready"}, 64'(x_issue_ready_o), 64'(1));
    @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] id, input logic [4:0] rd, input int unsigned cdelay,
                        input bit wrong_id, input bit kill, input int unsigned rdelay,
                        input string tag);
    logic        acc_obs;
    int unsigned hs;
    int unsigned cc;
    int unsigned dummy;
    bit          ok;
    bit          exp_acc;
    bit          seen;
    exp_acc = model_accepts(f3);
    issue_op(mk_instr(MAC_OPCODE, f3, rd), a, b, id, 2'b11, cdelay == 0, kill, acc_obs, hs, ok);
    check({tag, " issue_ready"}, 64'(ok), 64'(1));
    check({tag, " accept"}, 64'(acc_obs), 64'(exp_acc));
    if (!exp_acc || !ok) begin
      check({tag, " stays_idle"}, 64'(dbg_state_o), 64'(ST_IDLE));
      return;
    end
    cc = hs;
    if (cdelay > 0) begin
      if (wrong_id) commit_drive(id ^ 4'h1, 1'b0, dummy);
      for (int i = 1; i < int'(cdelay); i++) @(negedge clk);
      check({tag, " waiting"}, 64'(dbg_state_o), 64'(ST_WAIT_COMMIT));
      commit_drive(id, kill, cc);
    end
    if (kill) begin
      watch_no_result(tag);
    end else begin
      exp_q.push_back(model_exec(f3, a, b));
      wait_result(cc, tag, seen);
      if (seen) collect_result(rdelay, id, rd, tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        acc_obs;
    int unsigned hs;
    bit          ok;
    rst = 1'b1;
    x_result_ready_i = 1'b0;
    idle_inputs();
    // Own, fully-ready request during reset must not be taken.
    x_issue_valid_i        = 1'b1;
    x_issue_req_i.instr    = mk_instr(MAC_OPCODE, 3'd0, 5'd1);
    x_issue_req_i.rs_valid = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    check("rst issue_ready", 64'(x_issue_ready_o), 64'(0));
    check("rst accept", 64'(x_issue_resp_o), 64'(0));
    check("rst result_valid", 64'(x_result_valid_o), 64'(0));
    check("rst result", 64'(x_result_o), 64'(0));
    check("rst state", 64'(dbg_state_o), 64'(ST_IDLE));
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst ready", 64'(x_issue_ready_o), 64'(1));
    @(negedge clk);

    run_op(3'd0, 32'd3, 32'd5, 4'd4, 5'd7, 0, 1'b0, 1'b0, 0, "mul");

    run_op(3'd1, 32'd2, 32'd3, 4'd1, 5'd3, 0, 1'b0, 1'b0, 0, "mac1");
    run_op(3'd1, 32'd4, 32'd5, 4'd2, 5'd3, 1, 1'b0, 1'b0, 1, "mac2");
    run_op(3'd2, 32'd0, 32'd0, 4'd3, 5'd4, 0, 1'b0, 1'b0, 0, "accrd1");
    run_op(3'd2, 32'd0, 32'd0, 4'd5, 5'd4, 2, 1'b0, 1'b0, 0, "accrd2");

    run_op(3'd1, 32'd7, 32'd7, 4'd6, 5'd8, 2, 1'b1, 1'b1, 0, "kill_mac");
    run_op(3'd2, 32'd0, 32'd0, 4'd7, 5'd9, 0, 1'b0, 1'b0, 0, "kill_accrd");
    run_op(3'd0, 32'd7, 32'd7, 4'd8, 5'd9, 3, 1'b1, 1'b1, 0, "kill_mul");

    run_op(3'd0, 32'd11, 32'd13, 4'd9, 5'd10, 0, 1'b0, 1'b0, 3, "bp");
    run_op(3'd0, 32'hffff_ffff, 32'hffff_ffff, 4'd10, 5'd11, 0, 1'b0, 1'b0, 0, "wrap");

    // Foreign opcode: answered at once with accept=0.
    x_issue_valid_i        = 1'b1;
    x_issue_req_i.instr    = mk_instr(7'b0110011, 3'd0, 5'd3);
    x_issue_req_i.rs_valid = 2'b00;
    #1;
    check("foreign ready", 64'(x_issue_ready_o), 64'(1));
    check("foreign accept", 64'(x_issue_resp_o.accept), 64'(0));
    @(negedge clk);
    idle_inputs();
    check("foreign idle", 64'(dbg_state_o), 64'(ST_IDLE));
    // Own opcode missing rs2: held off.
    x_issue_valid_i        = 1'b1;
    x_issue_req_i.instr    = mk_instr(MAC_OPCODE, 3'd0, 5'd3);
    x_issue_req_i.rs_valid = 2'b01;
    #1;
    check("rsv01 ready", 64'(x_issue_ready_o), 64'(0));
    @(negedge clk);
    #1;
    check("rsv01 ready2", 64'(x_issue_ready_o), 64'(0));
    check("rsv01 idle", 64'(dbg_state_o), 64'(ST_IDLE));
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

    // Reset while an instruction is in EXEC.
    run_op(3'd1, 32'd9, 32'd9, 4'd11, 5'd12, 0, 1'b0, 1'b0, 0, "pre_rst_mac");
    issue_op(mk_instr(MAC_OPCODE, 3'd0, 5'd13), 32'd6, 32'd7, 4'd12, 2'b11, 1'b1, 1'b0,
             acc_obs, hs, ok);
    check("rst_exec state", 64'(dbg_state_o), 64'(ST_EXEC));
    rst = 1'b1;
    #1;
    check("rst_exec state_now", 64'(dbg_state_o), 64'(ST_IDLE));
    check("rst_exec ready", 64'(x_issue_ready_o), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    model_acc = '0;
    watch_no_result("rst_exec");
    #1;
    check("rst_exec ready_after", 64'(x_issue_ready_o), 64'(1));
    @(negedge clk);
    run_op(3'd2, 32'd0, 32'd0, 4'd13, 5'd14, 0, 1'b0, 1'b0, 0, "rst_accrd");

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      int unsigned cd;
      f3 = 3'($urandom_range(0, 2));
      a  = (n % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b  = (n % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      cd = $urandom_range(0, 3);
      run_op(f3, a, b, 4'($urandom_range(0, 15)), 5'($urandom_range(1, 31)), cd,
             (cd > 0) && ($urandom_range(0, 1) == 1), $urandom_range(0, 4) == 0,
             $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    check("scoreboard drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
